// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the pipelined LEGv8 core. It also holds the
// architectural NZCV flags, and honours stall (hold) and flush (bubble) from the hazard unit.
module ex_mem_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_nzcv,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [3:0]        flags_nzcv,
  output logic [3:0]        ex_flags_eff,
  output logic [REG_W-1:0]  fwd_rd,
  output logic              fwd_en
);

  localparam logic [REG_W-1:0] XZR = '1;

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] alu_q,        alu_d;
  logic [DATA_W-1:0] store_q,      store_d;
  logic [REG_W-1:0]  rd_q,         rd_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [3:0]        nzcv_q,       nzcv_d;

  logic capture;
  logic flags_upd;

  assign capture   = ~stall;
  assign flags_upd = capture & ~flush & ex_valid & ex_set_flags;

  always_comb begin
    // NOTE: every next-state value defaults to its held value first, so no path infers a latch.
    valid_d      = valid_q;
    alu_d        = alu_q;
    store_d      = store_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    nzcv_d       = nzcv_q;

    if (capture) begin
      // Data fields load unconditionally; a flushed slot is marked dead by its controls alone.
      alu_d   = ex_alu_result;
      store_d = ex_store_data;
      rd_d    = ex_rd;
      if (flush) begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
      end else begin
        valid_d      = ex_valid;
        reg_write_d  = ex_reg_write & ex_valid;
        mem_read_d   = ex_mem_read  & ex_valid;
        mem_write_d  = ex_mem_write & ex_valid;
        mem_to_reg_d = ex_mem_to_reg;
      end
    end

    if (flags_upd) nzcv_d = ex_nzcv;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data flops are reset as well, since the MEM stage must see all-zero outputs in reset.
      valid_q      <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      nzcv_q       <= 4'b0000;
    end else begin
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      nzcv_q       <= nzcv_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign flags_nzcv     = nzcv_q;

  // Same-instruction view of the flags, used by fused compare-and-branch in EX.
  assign ex_flags_eff = (ex_valid & ex_set_flags) ? ex_nzcv : nzcv_q;

  assign fwd_rd = rd_q;
  assign fwd_en = valid_q & reg_write_q & (rd_q != XZR);

endmodule
